// File: rtl/demux_arb_pkg.sv
// Shared definitions for the two-lane arbiter: FSM encoding, default sizes
// and the drop-counter width used when DEMUX_ARB_DROP_CNT_EN is defined.
package demux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } arb_state_t;

    localparam int DEFAULT_BITNUMBER = 5;
    localparam int DEFAULT_DEPTH     = 4;
    localparam int DROP_CNT_W        = 8;

endpackage

// File: rtl/demux_arb_fifo.sv
// Per-lane synchronous FIFO with registered empty/full flags and a
// fall-through read port (rdata always shows the oldest word).
module demux_arb_fifo
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    // A push against a full FIFO is lost even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/demux_arbiter.sv
// Two-lane buffered arbiter feeding a shared, registered data bus.
// Defining DEMUX_ARB_DROP_CNT_EN adds saturating per-lane drop counters.
module demux_arbiter
    import demux_arb_pkg::*;
#(
    parameter int BITNUMBER = DEFAULT_BITNUMBER,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push0,
    input  logic                  push1,
    input  logic [BITNUMBER-1:0]  data0,
    input  logic [BITNUMBER-1:0]  data1,
    input  logic                  pause0,
    input  logic                  pause1,
    output logic                  full0,
    output logic                  full1,
    output logic [BITNUMBER-1:0]  data_out,
    output logic                  valid_out0,
    output logic                  valid_out1,
    output logic [1:0]            arb_state
`ifdef DEMUX_ARB_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt0,
    output logic [DROP_CNT_W-1:0] drop_cnt1
`endif
);

    // Handshake: pushN writes dataN unless the lane is full (then it is dropped);
    // pauseN high blocks grants to lane N; valid_outN marks data_out for lane N
    // for exactly one cycle per word, with no backpressure on the output side.

    logic [BITNUMBER-1:0] head0;
    logic [BITNUMBER-1:0] head1;
    logic                 empty0;
    logic                 empty1;
    logic                 elig0;
    logic                 elig1;
    logic                 grant0;
    logic                 grant1;
    logic                 last_grant;
    arb_state_t           state;

    demux_arb_fifo #(.WIDTH(BITNUMBER), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .pop   (grant0),
        .wdata (data0),
        .rdata (head0),
        .empty (empty0),
        .full  (full0)
    );

    demux_arb_fifo #(.WIDTH(BITNUMBER), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .pop   (grant1),
        .wdata (data1),
        .rdata (head1),
        .empty (empty1),
        .full  (full1)
    );

    assign elig0 = !empty0 && !pause0;
    assign elig1 = !empty1 && !pause1;

    // last_grant: 0 = lane 0 was served last, 1 = lane 1 (reset value, so lane 0 goes first).
    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            data_out   <= '0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
        end else begin
            valid_out0 <= grant0;
            valid_out1 <= grant1;
            if (grant0) begin
                state      <= SERVE0;
                last_grant <= 1'b0;
                data_out   <= head0;
            end else if (grant1) begin
                state      <= SERVE1;
                last_grant <= 1'b1;
                data_out   <= head1;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign arb_state = state;

`ifdef DEMUX_ARB_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt0 <= '0;
            drop_cnt1 <= '0;
        end else begin
            if (push0 && full0 && (drop_cnt0 != {DROP_CNT_W{1'b1}}))
                drop_cnt0 <= drop_cnt0 + DROP_CNT_W'(1);
            if (push1 && full1 && (drop_cnt1 != {DROP_CNT_W{1'b1}}))
                drop_cnt1 <= drop_cnt1 + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_arbiter.sv
// Directed bench for demux_arbiter: reset, streaming, contention, pause,
// overflow (incl. DEMUX_ARB_DROP_CNT_EN counters) and mid-stream reset.
module tb_demux_arbiter;
    import demux_arb_pkg::*;

    localparam int W = 5;
    localparam int D = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         push0  = 1'b0;
    logic         push1  = 1'b0;
    logic         pause0 = 1'b0;
    logic         pause1 = 1'b0;
    logic [W-1:0] data0  = '0;
    logic [W-1:0] data1  = '0;
    logic [W-1:0] data_out;
    logic         full0;
    logic         full1;
    logic         valid_out0;
    logic         valid_out1;
    logic [1:0]   arb_state;
`ifdef DEMUX_ARB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt0;
    logic [DROP_CNT_W-1:0] drop_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_arbiter #(.BITNUMBER(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .push0      (push0),
        .push1      (push1),
        .data0      (data0),
        .data1      (data1),
        .pause0     (pause0),
        .pause1     (pause1),
        .full0      (full0),
        .full1      (full1),
        .data_out   (data_out),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .arb_state  (arb_state)
`ifdef DEMUX_ARB_DROP_CNT_EN
        ,
        .drop_cnt0  (drop_cnt0),
        .drop_cnt1  (drop_cnt1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b0;
        push0  = 1'b0;
        push1  = 1'b0;
        pause0 = 1'b0;
        pause1 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({full1, full0, valid_out1, valid_out0, data_out, arb_state} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got f1=%b f0=%b v1=%b v0=%b data=%0d st=%0d, expected all 0",
                     full1, full0, valid_out1, valid_out0, data_out, arb_state);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({full1, full0, valid_out1, valid_out0, data_out, arb_state} !== '0) begin
            errors++;
            $display("FAIL reset_release: got f1=%b f0=%b v1=%b v0=%b data=%0d st=%0d, expected all 0",
                     full1, full0, valid_out1, valid_out0, data_out, arb_state);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        push0 = 1'b1; data0 = 5'd5;
        tick();
        checks++;
        if ({valid_out1, valid_out0} !== 2'b00) begin
            errors++;
            $display("FAIL stream_latency: got v1v0=%b expected 00", {valid_out1, valid_out0});
        end
        data0 = 5'd7;
        tick();
        push0 = 1'b0;
        checks++;
        if ({valid_out1, valid_out0, data_out} !== {2'b01, 5'd5}) begin
            errors++;
            $display("FAIL stream_first: got v1=%b v0=%b data=%0d expected v1=0 v0=1 data=5",
                     valid_out1, valid_out0, data_out);
        end
        checks++;
        if (arb_state !== 2'b01) begin
            errors++;
            $display("FAIL stream_state: got %0d expected 1", arb_state);
        end
        tick();
        checks++;
        if ({valid_out1, valid_out0, data_out} !== {2'b01, 5'd7}) begin
            errors++;
            $display("FAIL stream_second: got v1=%b v0=%b data=%0d expected v1=0 v0=1 data=7",
                     valid_out1, valid_out0, data_out);
        end
        tick();
        checks++;
        if ({valid_out1, valid_out0, data_out, arb_state} !== {2'b00, 5'd7, 2'b00}) begin
            errors++;
            $display("FAIL stream_idle_hold: got v1=%b v0=%b data=%0d st=%0d expected v=00 data=7 st=0",
                     valid_out1, valid_out0, data_out, arb_state);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            push0 = 1'b1; data0 = 5'd4;
            push1 = 1'b1; data1 = 5'd9;
            tick();
            push0 = 1'b0;
            push1 = 1'b0;
            tick();
            checks++;
            if ({valid_out1, valid_out0, data_out} !== {2'b01, 5'd4}) begin
                errors++;
                $display("FAIL contention_first pass %0d: got v1=%b v0=%b data=%0d expected v1=0 v0=1 data=4",
                         pass, valid_out1, valid_out0, data_out);
            end
            tick();
            checks++;
            if ({valid_out1, valid_out0, data_out} !== {2'b10, 5'd9}) begin
                errors++;
                $display("FAIL contention_second pass %0d: got v1=%b v0=%b data=%0d expected v1=1 v0=0 data=9",
                         pass, valid_out1, valid_out0, data_out);
            end
            tick();
            checks++;
            if ({valid_out1, valid_out0} !== 2'b00) begin
                errors++;
                $display("FAIL contention_drain pass %0d: got v1v0=%b expected 00",
                         pass, {valid_out1, valid_out0});
            end
        end
    endtask

    task automatic test_pause();
        apply_reset();
        pause1 = 1'b1;
        push1 = 1'b1; data1 = 5'd3;
        tick();
        push1 = 1'b0;
        push0 = 1'b1; data0 = 5'd5;
        tick();
        push0 = 1'b0;
        checks++;
        if ({valid_out1, valid_out0} !== 2'b00) begin
            errors++;
            $display("FAIL pause_blocked: got v1v0=%b expected 00", {valid_out1, valid_out0});
        end
        tick();
        checks++;
        if ({valid_out1, valid_out0, data_out} !== {2'b01, 5'd5}) begin
            errors++;
            $display("FAIL pause_lane0: got v1=%b v0=%b data=%0d expected v1=0 v0=1 data=5",
                     valid_out1, valid_out0, data_out);
        end
        tick();
        checks++;
        if ({valid_out1, valid_out0, data_out} !== {2'b00, 5'd5}) begin
            errors++;
            $display("FAIL pause_held: got v1=%b v0=%b data=%0d expected v1=0 v0=0 data=5",
                     valid_out1, valid_out0, data_out);
        end
        pause1 = 1'b0;
        tick();
        checks++;
        if ({valid_out1, valid_out0, data_out, arb_state} !== {2'b10, 5'd3, 2'b10}) begin
            errors++;
            $display("FAIL pause_release: got v1=%b v0=%b data=%0d st=%0d expected v1=1 v0=0 data=3 st=2",
                     valid_out1, valid_out0, data_out, arb_state);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] vals [4];
        vals[0] = 5'd4; vals[1] = 5'd7; vals[2] = 5'd9; vals[3] = 5'd5;
        apply_reset();
        pause0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push0 = 1'b1; data0 = vals[i];
            tick();
        end
        checks++;
        if ({full1, full0, valid_out1, valid_out0} !== 4'b0100) begin
            errors++;
            $display("FAIL overflow_full: got f1=%b f0=%b v1=%b v0=%b expected f0=1 others 0",
                     full1, full0, valid_out1, valid_out0);
        end
        data0 = 5'd3;
        tick();
        checks++;
        if (full0 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_still_full: got %b expected 1", full0);
        end
`ifdef DEMUX_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL overflow_drop_cnt1: got %0d expected 1", drop_cnt0);
        end
`endif
        // Push on the same edge as the first pop: lane is still full, so it is dropped.
        data0 = 5'd8;
        pause0 = 1'b0;
        tick();
        push0 = 1'b0;
        checks++;
        if ({full0, valid_out0, data_out} !== {1'b0, 1'b1, 5'd4}) begin
            errors++;
            $display("FAIL overflow_first_pop: got f0=%b v0=%b data=%0d expected f0=0 v0=1 data=4",
                     full0, valid_out0, data_out);
        end
`ifdef DEMUX_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt0 !== 8'd2) begin
            errors++;
            $display("FAIL overflow_drop_cnt2: got %0d expected 2", drop_cnt0);
        end
`endif
        for (int j = 1; j < 4; j++) begin
            tick();
            checks++;
            if ({valid_out1, valid_out0, data_out} !== {2'b01, vals[j]}) begin
                errors++;
                $display("FAIL overflow_order[%0d]: got v1=%b v0=%b data=%0d expected v1=0 v0=1 data=%0d",
                         j, valid_out1, valid_out0, data_out, vals[j]);
            end
        end
        tick();
        checks++;
        if ({full0, valid_out1, valid_out0, data_out} !== {3'b000, 5'd5}) begin
            errors++;
            $display("FAIL overflow_empty: got f0=%b v1=%b v0=%b data=%0d expected 0 0 0 data=5",
                     full0, valid_out1, valid_out0, data_out);
        end
    endtask

    task automatic test_midstream_reset();
        apply_reset();
        pause0 = 1'b1;
        push0 = 1'b1; data0 = 5'd6;
        push1 = 1'b1; data1 = 5'd9;
        tick();
        data0 = 5'd1;
        push1 = 1'b0;
        tick();
        push0 = 1'b0;
        checks++;
        if ({valid_out1, valid_out0, data_out} !== {2'b10, 5'd9}) begin
            errors++;
            $display("FAIL midreset_pre: got v1=%b v0=%b data=%0d expected v1=1 v0=0 data=9",
                     valid_out1, valid_out0, data_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({full1, full0, valid_out1, valid_out0, data_out, arb_state} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got f1=%b f0=%b v1=%b v0=%b data=%0d st=%0d expected all 0",
                     full1, full0, valid_out1, valid_out0, data_out, arb_state);
        end
        pause0 = 1'b0;
        push0 = 1'b1; data0 = 5'd13;
        tick();
        tick();
        push0 = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({valid_out1, valid_out0, data_out} !== '0) begin
                errors++;
                $display("FAIL midreset_quiet[%0d]: got v1=%b v0=%b data=%0d expected 0 0 0",
                         k, valid_out1, valid_out0, data_out);
            end
        end
        push0 = 1'b1; data0 = 5'd10;
        tick();
        push0 = 1'b0;
        tick();
        checks++;
        if ({valid_out1, valid_out0, data_out} !== {2'b01, 5'd10}) begin
            errors++;
            $display("FAIL midreset_resume: got v1=%b v0=%b data=%0d expected v1=0 v0=1 data=10",
                     valid_out1, valid_out0, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_contention();
        test_pause();
        test_overflow();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
